qft_row_scheduler: RTL

//  Sequences the signed QFT MAC datapath controller over a programmable number of state-vector rows.
//  Per row: one-cycle strt_qft pulse, wait for update_state. Optionally a one-cycle strt_abs pulse, wait for update_state.

---
 rtl/qft_row_scheduler_pkg.sv | 22 ++
 rtl/qft_row_scheduler_if.sv | 27 ++
 rtl/qft_row_scheduler_wdog.sv | 44 ++++
 rtl/qft_row_scheduler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/qft_row_scheduler_pkg.sv
// qft_sched_pkg: shared types and default sizing for the QFT row scheduler.
// Optional watchdog feature is enabled by defining QFT_SCHED_TIMEOUT_EN.
package qft_sched_pkg;

  localparam int N_QUBITS_DEF = 2;
  localparam int TIMEOUT_DEF  = 64;
  localparam int ROWS         = 2 ** N_QUBITS_DEF;
  localparam int TO_W         = $clog2(TIMEOUT_DEF + 1);

  // ERR keeps its encoding even when the watchdog is compiled out.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE_QFT = 3'd1,
    S_WAIT_QFT  = 3'd2,
    S_ISSUE_ABS = 3'd3,
    S_WAIT_ABS  = 3'd4,
    S_ADVANCE   = 3'd5,
    S_FINISH    = 3'd6,
    S_ERR       = 3'd7
  } sched_state_t;

endpackage

// File: rtl/qft_row_scheduler_if.sv
// Host command port plus the datapath start/complete handshake.
// master = host/datapath side, slave = the scheduler.
interface qft_row_scheduler_if
  import qft_sched_pkg::*;
#(
  parameter int N_QUBITS = N_QUBITS_DEF
) ();

  logic                cmd_valid;
  logic                cmd_ready;
  logic [N_QUBITS:0]   cmd_nrows;
  logic                cmd_abs_en;
  logic                strt_qft;
  logic                strt_abs;
  logic                update_state;

  modport master (
    output cmd_valid, cmd_nrows, cmd_abs_en, update_state,
    input  cmd_ready, strt_qft, strt_abs
  );

  modport slave (
    input  cmd_valid, cmd_nrows, cmd_abs_en, update_state,
    output cmd_ready, strt_qft, strt_abs
  );

endinterface

// File: rtl/qft_row_scheduler_wdog.sv
// qft_sched_wdog: wait-state watchdog for the row scheduler.
// Only instantiated when QFT_SCHED_TIMEOUT_EN is defined.
// expire_o is raised on the TIMEOUT-th consecutive enabled cycle.
module qft_sched_wdog
  import qft_sched_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = TO_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == LAST);

  // Count enabled cycles, restart on clear, stop once expired.
  always_comb begin
    // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/qft_row_scheduler.sv
// qft_row_scheduler: walks the QFT MAC datapath over cmd_nrows state-vector
// rows, pulsing strt_qft (and optionally strt_abs) per row and waiting for
// update_state after each pulse. Define QFT_SCHED_TIMEOUT_EN to add a wait
// watchdog that parks the FSM in ERR and raises the sticky timeout flag.
module qft_row_scheduler
  import qft_sched_pkg::*;
#(
  parameter int N_QUBITS = N_QUBITS_DEF
`ifdef QFT_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  qft_row_scheduler_if.slave     bus,
  input  logic                   abort,
  output logic [N_QUBITS-1:0]    row_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout
);

  localparam int ROW_W = N_QUBITS;
  localparam logic [ROW_W:0] ROWS_N = {1'b1, {ROW_W{1'b0}}};

  sched_state_t     state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W:0]   nrows_q, nrows_d;
  logic             abs_en_q, abs_en_d;
  logic             done_q;
  logic             accept;
  logic             last_row;
  logic [ROW_W:0]   nrows_clamped;

  // Abort takes precedence over a new command, so ready drops with it.
  assign bus.cmd_ready  = (state_q == S_IDLE) && !abort;
  assign accept         = bus.cmd_valid && bus.cmd_ready;
  assign nrows_clamped  = (bus.cmd_nrows > ROWS_N) ? ROWS_N : bus.cmd_nrows;
  assign last_row       = ({1'b0, row_q} == (nrows_q - 1'b1));

  // Pulses are suppressed in an abort cycle.
  assign bus.strt_qft = (state_q == S_ISSUE_QFT) && !abort;
  assign bus.strt_abs = (state_q == S_ISSUE_ABS) && !abort;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign row_idx      = row_q;

`ifdef QFT_SCHED_TIMEOUT_EN
  logic wd_clear, wd_en, wd_expire;
  logic timeout_q, timeout_d;

  assign wd_clear = (state_q == S_IDLE) || (state_q == S_ISSUE_QFT) ||
                    (state_q == S_ISSUE_ABS);
  assign wd_en    = ((state_q == S_WAIT_QFT) || (state_q == S_WAIT_ABS)) &&
                    !bus.update_state;

  qft_sched_wdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   ($clog2(TIMEOUT + 1))
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (wd_clear),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Next-state, row counter and latched command configuration.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    nrows_d  = nrows_q;
    abs_en_d = abs_en_q;
`ifdef QFT_SCHED_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            nrows_d  = nrows_clamped;
            abs_en_d = bus.cmd_abs_en;
            row_d    = '0;
            state_d  = (nrows_clamped == '0) ? S_FINISH : S_ISSUE_QFT;
`ifdef QFT_SCHED_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
          end
        end
        S_ISSUE_QFT: state_d = S_WAIT_QFT;
        S_WAIT_QFT: begin
          if (bus.update_state) begin
            state_d = abs_en_q ? S_ISSUE_ABS : S_ADVANCE;
          end
`ifdef QFT_SCHED_TIMEOUT_EN
          else if (wd_expire) begin
            state_d   = S_ERR;
            timeout_d = 1'b1;
          end
`endif
        end
        S_ISSUE_ABS: state_d = S_WAIT_ABS;
        S_WAIT_ABS: begin
          if (bus.update_state) begin
            state_d = S_ADVANCE;
          end
`ifdef QFT_SCHED_TIMEOUT_EN
          else if (wd_expire) begin
            state_d   = S_ERR;
            timeout_d = 1'b1;
          end
`endif
        end
        S_ADVANCE: begin
          if (last_row) begin
            state_d = S_FINISH;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_ISSUE_QFT;
          end
        end
        S_FINISH: state_d = S_IDLE;
`ifdef QFT_SCHED_TIMEOUT_EN
        S_ERR: state_d = S_ERR;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; done is registered so it lands the cycle after FINISH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      nrows_q  <= '0;
      abs_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      nrows_q  <= nrows_d;
      abs_en_q <= abs_en_d;
      done_q   <= (state_q == S_FINISH) && !abort;
    end
  end

`ifdef QFT_SCHED_TIMEOUT_EN
  // Sticky timeout flag, cleared only by the next accepted command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule
